// File: rtl/print_pkg.sv
// Shared encodings for the number-to-text streamer: radix codes, ASCII constants,
// FSM states and the decimal digit-count helper.
package print_pkg;

  localparam logic [1:0] MODE_BIN = 2'd0;
  localparam logic [1:0] MODE_HEX = 2'd1;
  localparam logic [1:0] MODE_DEC = 2'd2;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] LET_A = 8'h41;
  localparam logic [7:0] LET_B = 8'h62;
  localparam logic [7:0] LET_X = 8'h78;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE, CONVERT, PREFIX0, PREFIX1, DIGITS, TERM_CR, TERM_LF, FINISH
  } state_e;

  // 1233/4096 approximates log10(2); yields the decimal digits of 2^width-1.
  function automatic int dec_digits(input int width);
    return ((width * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per cycle, WIDTH steps.
// The first step is folded into the load cycle, so the result is ready WIDTH cycles later.
module bcd_double_dabble #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shift_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj = add3(bcd_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (load) begin
      // BCD starts at zero, so no correction is needed before the first shift.
      shift_q <= bin_in << 1;
      bcd_q   <= {{(4*DIGITS-1){1'b0}}, bin_in[WIDTH-1]};
      cnt_q   <= CNT_W'(WIDTH - 1);
      busy_q  <= (WIDTH > 1);
    end else if (busy_q) begin
      {bcd_q, shift_q} <= {adj, shift_q} << 1;
      cnt_q            <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/ascii_num_streamer.sv
// Latches a number on start and streams its bin/hex/dec ASCII text one character
// per valid/ready handshake, with optional radix prefix, zero suppression and CR/LF.
module ascii_num_streamer
  import print_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LZ_SUPPRESS = 0,
  parameter int PREFIX_EN   = 1,
  parameter int TERM_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] number_in,
  output logic             busy,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             done
);

  localparam int HEX_DIGITS = (WIDTH + 3) / 4;
  localparam int DEC_DIGITS = dec_digits(WIDTH);
  localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e                  state_q;
  logic [1:0]              mode_q;
  logic [WIDTH-1:0]        num_q;
  logic [IDX_W-1:0]        idx_q;
  logic [7:0]              char_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    dd_load;
  logic                    dd_busy;
  logic [4*DEC_DIGITS-1:0] bcd;
  logic [3:0]              cur_digit;
  logic [3:0]              next_digit;
  logic [3:0]              first_idle;

  function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] m);
    logic [IDX_W-1:0] r;
    case (m)
      MODE_BIN: r = IDX_W'(WIDTH - 1);
      MODE_DEC: r = IDX_W'(DEC_DIGITS - 1);
      default:  r = IDX_W'(HEX_DIGITS - 1);
    endcase
    return r;
  endfunction

  // Reserved mode 3 falls into the hex branch; a partial top nibble is zero-extended.
  function automatic logic [3:0] digit_of(input logic [1:0]              m,
                                          input logic [WIDTH-1:0]        v,
                                          input logic [4*DEC_DIGITS-1:0] b,
                                          input logic [IDX_W-1:0]        i);
    logic [WIDTH-1:0]        vs;
    logic [4*HEX_DIGITS-1:0] hx;
    logic [4*DEC_DIGITS-1:0] bs;
    logic [3:0]              d;
    vs            = v >> i;
    hx            = '0;
    hx[WIDTH-1:0] = v;
    hx            = hx >> {i, 2'b00};
    bs            = b >> {i, 2'b00};
    case (m)
      MODE_BIN: d = {3'b000, vs[0]};
      MODE_DEC: d = bs[3:0];
      default:  d = hx[3:0];
    endcase
    return d;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (ZERO + {4'h0, d}) : (LET_A + {4'h0, d} - 8'd10);
  endfunction

  assign dd_load    = (state_q == IDLE) && start && (mode == MODE_DEC);
  assign cur_digit  = digit_of(mode_q, num_q, bcd, idx_q);
  assign next_digit = digit_of(mode_q, num_q, bcd, idx_q - 1'b1);
  assign first_idle = digit_of(mode, number_in, bcd, last_idx(mode));

  bcd_double_dabble #(
    .WIDTH  (WIDTH),
    .DIGITS (DEC_DIGITS)
  ) u_dd (
    .clk     (clk),
    .rst     (rst),
    .load    (dd_load),
    .bin_in  (number_in),
    .busy    (dd_busy),
    .bcd_out (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          mode_q <= mode;
          num_q  <= number_in;
          idx_q  <= last_idx(mode);
          busy_q <= 1'b1;
          if (mode == MODE_DEC) begin
            state_q <= CONVERT;
          end else if (PREFIX_EN != 0) begin
            state_q <= PREFIX0;
            valid_q <= 1'b1;
            char_q  <= ZERO;
          end else begin
            state_q <= DIGITS;
            valid_q <= (LZ_SUPPRESS == 0);
            char_q  <= to_ascii(first_idle);
          end
        end
        CONVERT: if (!dd_busy) begin
          state_q <= DIGITS;
          valid_q <= (LZ_SUPPRESS == 0);
          char_q  <= to_ascii(cur_digit);
        end
        PREFIX0: if (char_ready) begin
          state_q <= PREFIX1;
          char_q  <= (mode_q == MODE_BIN) ? LET_B : LET_X;
        end
        PREFIX1: if (char_ready) begin
          state_q <= DIGITS;
          valid_q <= (LZ_SUPPRESS == 0);
          char_q  <= to_ascii(cur_digit);
        end
        DIGITS: begin
          // valid low here only while leading zeros are still being skipped
          if (!valid_q) begin
            if ((cur_digit == 4'd0) && (idx_q != '0)) begin
              idx_q <= idx_q - 1'b1;
            end else begin
              valid_q <= 1'b1;
              char_q  <= to_ascii(cur_digit);
            end
          end else if (char_ready) begin
            if (idx_q == '0) begin
              if (TERM_EN != 0) begin
                state_q <= TERM_CR;
                char_q  <= CR;
              end else begin
                state_q <= FINISH;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q  <= idx_q - 1'b1;
              char_q <= to_ascii(next_digit);
            end
          end
        end
        TERM_CR: if (char_ready) begin
          state_q <= TERM_LF;
          char_q  <= LF;
        end
        TERM_LF: if (char_ready) begin
          state_q <= FINISH;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ascii_num_streamer.sv
// Directed bench for ascii_num_streamer: three instances cover the default build,
// leading-zero suppression, and a 12-bit build without prefix or terminator.
module tb_ascii_num_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [3];
  logic [1:0]  mode_s  [3];
  logic [31:0] num_s   [3];
  logic        ready_s [3];
  logic        busy_w  [3];
  logic [7:0]  char_w  [3];
  logic        valid_w [3];
  logic        done_w  [3];

  int n_checks = 0;
  int n_pass   = 0;

  string      cap_s;
  int         cap_n, cap_first, cap_last, cap_done_at, cap_dones, cap_busy_lo;
  logic       cap_hold_v [3];
  logic [7:0] cap_hold_c [3];

  always #5 clk = ~clk;

  ascii_num_streamer #(.WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .number_in(num_s[0]),
    .busy(busy_w[0]), .char_out(char_w[0]), .char_valid(valid_w[0]),
    .char_ready(ready_s[0]), .done(done_w[0])
  );

  ascii_num_streamer #(.WIDTH(32), .LZ_SUPPRESS(1)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .number_in(num_s[1]),
    .busy(busy_w[1]), .char_out(char_w[1]), .char_valid(valid_w[1]),
    .char_ready(ready_s[1]), .done(done_w[1])
  );

  ascii_num_streamer #(.WIDTH(12), .PREFIX_EN(0), .TERM_EN(0)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .mode(mode_s[2]), .number_in(num_s[2][11:0]),
    .busy(busy_w[2]), .char_out(char_w[2]), .char_valid(valid_w[2]),
    .char_ready(ready_s[2]), .done(done_w[2])
  );

  function automatic string vis(input string s);
    string r;
    r = s;
    for (int i = 0; i < r.len(); i++) begin
      if (r.getc(i) == 8'h0D) r.putc(i, 8'h5E);
      else if (r.getc(i) == 8'h0A) r.putc(i, 8'h7C);
    end
    return r;
  endfunction

  // Starts a transaction on instance k and records what comes out. Cycle 1 is the
  // cycle right after the start edge. Optional stall on the first stall_ch seen,
  // optional ignored start pulse (with new operands) at cycle inj_cyc.
  task automatic capture(input int k, input logic [1:0] m, input logic [31:0] n,
                         input logic [7:0] stall_ch, input int inj_cyc);
    int stall_left;
    bit stalled;
    @(negedge clk);
    start_s[k] = 1'b1; mode_s[k] = m; num_s[k] = n; ready_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    cap_s = "........................................";
    cap_n = 0; cap_first = -1; cap_last = -1; cap_done_at = -1; cap_dones = 0; cap_busy_lo = 0;
    stall_left = 0; stalled = 1'b0;
    for (int i = 0; i < 3; i++) begin cap_hold_v[i] = 1'b0; cap_hold_c[i] = 8'h00; end
    for (int cyc = 1; cyc <= 120; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start_s[k] = 1'b0;
      if (cyc == inj_cyc) begin
        start_s[k] = 1'b1; mode_s[k] = 2'd2; num_s[k] = 32'h12345678;
      end
      if (done_w[k]) begin
        cap_dones++;
        if (cap_done_at < 0) cap_done_at = cyc;
      end
      if (cap_done_at < 0 && !busy_w[k]) cap_busy_lo++;
      if (!stalled && stall_ch != 8'h00 && valid_w[k] && char_w[k] == stall_ch) begin
        stalled = 1'b1; stall_left = 3;
      end
      if (stall_left > 0) begin
        cap_hold_v[3-stall_left] = valid_w[k];
        cap_hold_c[3-stall_left] = char_w[k];
        stall_left--;
        ready_s[k] = 1'b0;
      end else begin
        ready_s[k] = 1'b1;
      end
      if (valid_w[k] && ready_s[k]) begin
        if (cap_n < 40) cap_s.putc(cap_n, char_w[k]);
        cap_n++;
        if (cap_first < 0) cap_first = cyc;
        cap_last = cyc;
      end
      if (cap_done_at > 0 && cyc >= cap_done_at + 3) break;
    end
    start_s[k] = 1'b0;
    cap_s = (cap_n == 0) ? "" : cap_s.substr(0, ((cap_n > 40) ? 40 : cap_n) - 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (busy_w[k] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", k, busy_w[k]); else n_pass++;
      n_checks++; if (valid_w[k] !== 1'b0) $display("FAIL reset_valid[%0d] got %b want 0", k, valid_w[k]); else n_pass++;
      n_checks++; if (char_w[k] !== 8'h00) $display("FAIL reset_char[%0d] got %h want 00", k, char_w[k]); else n_pass++;
      n_checks++; if (done_w[k] !== 1'b0) $display("FAIL reset_done[%0d] got %b want 0", k, done_w[k]); else n_pass++;
    end
    start_s[0] = 1'b1; mode_s[0] = 2'd1; num_s[0] = 32'h0000BEEF;
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL rst_vs_start_busy got %b want 0", busy_w[0]); else n_pass++;
    n_checks++; if (valid_w[0] !== 1'b0) $display("FAIL rst_vs_start_valid got %b want 0", valid_w[0]); else n_pass++;
    rst = 1'b0; start_s[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL rst_vs_start_after got %b want 0", busy_w[0]); else n_pass++;
  endtask

  task automatic test_hex_basic();
    string exp;
    exp = "0x0000BEEF\015\012";
    capture(0, 2'd1, 32'h0000BEEF, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL hex_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_first !== 1) $display("FAIL hex_first got %0d want 1", cap_first); else n_pass++;
    n_checks++; if (cap_last !== 12) $display("FAIL hex_last got %0d want 12", cap_last); else n_pass++;
    n_checks++; if (cap_done_at !== 13) $display("FAIL hex_done_cycle got %0d want 13", cap_done_at); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL hex_done_count got %0d want 1", cap_dones); else n_pass++;
    n_checks++; if (cap_busy_lo !== 0) $display("FAIL hex_busy_gap got %0d want 0", cap_busy_lo); else n_pass++;
  endtask

  task automatic test_dec_max();
    string exp;
    exp = "4294967295\015\012";
    capture(0, 2'd2, 32'hFFFFFFFF, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL dec_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_first !== 33) $display("FAIL dec_first got %0d want 33", cap_first); else n_pass++;
    n_checks++; if (cap_last !== 44) $display("FAIL dec_last got %0d want 44", cap_last); else n_pass++;
    n_checks++; if (cap_done_at !== 45) $display("FAIL dec_done_cycle got %0d want 45", cap_done_at); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL dec_done_count got %0d want 1", cap_dones); else n_pass++;
    n_checks++; if (cap_busy_lo !== 0) $display("FAIL dec_busy_gap got %0d want 0", cap_busy_lo); else n_pass++;
  endtask

  task automatic test_lz_bin();
    string exp;
    exp = "0b0\015\012";
    capture(1, 2'd0, 32'd0, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL lz_zero_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL lz_zero_done got %0d want 1", cap_dones); else n_pass++;
    exp = "0b101\015\012";
    capture(1, 2'd0, 32'd5, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL lz_five_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL lz_five_done got %0d want 1", cap_dones); else n_pass++;
  endtask

  task automatic test_backpressure();
    string exp;
    exp = "0x0000BEEF\015\012";
    capture(0, 2'd1, 32'h0000BEEF, 8'h45, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cap_hold_v[i] !== 1'b1) $display("FAIL bp_valid_hold[%0d] got %b want 1", i, cap_hold_v[i]); else n_pass++;
      n_checks++; if (cap_hold_c[i] !== 8'h45) $display("FAIL bp_char_hold[%0d] got %h want 45", i, cap_hold_c[i]); else n_pass++;
    end
    n_checks++; if (cap_s != exp) $display("FAIL bp_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_done_at !== 16) $display("FAIL bp_done_cycle got %0d want 16", cap_done_at); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL bp_done_count got %0d want 1", cap_dones); else n_pass++;
  endtask

  task automatic test_ignore_and_abort();
    string exp;
    int    dn;
    int    vh;
    exp = "0x0000BEEF\015\012";
    capture(0, 2'd1, 32'h0000BEEF, 8'h00, 4);
    n_checks++; if (cap_s != exp) $display("FAIL busy_start_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_done_at !== 13) $display("FAIL busy_start_done got %0d want 13", cap_done_at); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL busy_start_done_count got %0d want 1", cap_dones); else n_pass++;

    @(negedge clk);
    start_s[0] = 1'b1; mode_s[0] = 2'd1; num_s[0] = 32'hCAFE0000; ready_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (char_w[0] !== 8'h46 || valid_w[0] !== 1'b1)
      $display("FAIL abort_pre_char got %h/%b want 46/1", char_w[0], valid_w[0]); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_w[0] !== 1'b0) $display("FAIL abort_valid got %b want 0", valid_w[0]); else n_pass++;
    n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_w[0]); else n_pass++;
    n_checks++; if (done_w[0] !== 1'b0) $display("FAIL abort_done got %b want 0", done_w[0]); else n_pass++;
    rst = 1'b0;
    dn = 0; vh = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_w[0]) dn++;
      if (valid_w[0]) vh++;
    end
    n_checks++; if (dn !== 0) $display("FAIL abort_late_done got %0d want 0", dn); else n_pass++;
    n_checks++; if (vh !== 0) $display("FAIL abort_late_valid got %0d want 0", vh); else n_pass++;

    exp = "0x1234ABCD\015\012";
    capture(0, 2'd1, 32'h1234ABCD, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL restart_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_done_at !== 13) $display("FAIL restart_done got %0d want 13", cap_done_at); else n_pass++;
  endtask

  task automatic test_narrow();
    string exp;
    exp = "ABC";
    capture(2, 2'd1, 32'h00000ABC, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL w12_hex_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_first !== 1) $display("FAIL w12_hex_first got %0d want 1", cap_first); else n_pass++;
    n_checks++; if (cap_done_at !== 4) $display("FAIL w12_hex_done got %0d want 4", cap_done_at); else n_pass++;
    exp = "4095";
    capture(2, 2'd2, 32'd4095, 8'h00, 0);
    n_checks++; if (cap_s != exp) $display("FAIL w12_dec_text got '%s' want '%s'", vis(cap_s), vis(exp)); else n_pass++;
    n_checks++; if (cap_first !== 13) $display("FAIL w12_dec_first got %0d want 13", cap_first); else n_pass++;
    n_checks++; if (cap_done_at !== 17) $display("FAIL w12_dec_done got %0d want 17", cap_done_at); else n_pass++;
    n_checks++; if (cap_dones !== 1) $display("FAIL w12_dec_done_count got %0d want 1", cap_dones); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; mode_s[k] = 2'd0; num_s[k] = 32'd0; ready_s[k] = 1'b1;
    end
    test_reset();
    test_hex_basic();
    test_dec_max();
    test_lz_bin();
    test_backpressure();
    test_ignore_and_abort();
    test_narrow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ascii_num_streamer.md
Name: ascii_num_streamer

Overview:
Sequential number-to-text engine. It latches a WIDTH-bit value on a start strobe and emits its ASCII representation one character per valid/ready handshake. Output radix is selectable at run time: binary, hexadecimal or unsigned decimal. Optional leading-zero suppression, radix prefix and CR/LF terminator are available. Sits between status/measurement logic and the UART TX byte interface of the function-generator front end.

Parameters:
WIDTH, 32, bit width of number_in (1..64)
LZ_SUPPRESS, 0, 1 = drop leading zero digits (at least one digit always emitted)
PREFIX_EN, 1, 1 = emit "0b" (binary) or "0x" (hex) before digits; no prefix for decimal
TERM_EN, 1, 1 = emit CR (8'h0D) then LF (8'h0A) after the last digit

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; sampled only when busy=0
mode  input  2  radix: 0=bin, 1=hex, 2=dec, 3=reserved (treated as hex); sampled with start
number_in  input  WIDTH  value to print; sampled with start
busy  output  1  high from the cycle after accepted start until done
char_out  output  8  ASCII character
char_valid  output  1  char_out is valid
char_ready  input  1  consumer accepts char_out when char_valid & char_ready
done  output  1  one-cycle pulse after the final character is accepted

Behaviour:
- Reset: busy=0, char_valid=0, char_out=8'h00, done=0, FSM=IDLE. Reset mid-stream aborts: the next cycle is IDLE with valid low, and no done pulse.
- Digit counts:
  - bin = WIDTH
  - hex = ceil(WIDTH/4); for a partial top nibble, the upper bits are zero-extended
  - dec = DEC_DIGITS = ((WIDTH*1233)>>12)+1 (10 for WIDTH=32)
- Digit characters: 0-9 map to 8'h30+d; A-F map to 8'h41+(d-10), uppercase.
- FSM states: IDLE, CONVERT, PREFIX0, PREFIX1, DIGITS, TERM_CR, TERM_LF, FINISH.
  - IDLE: on start, latch mode and number_in, set busy. Go to CONVERT if dec, else PREFIX0 if PREFIX_EN, else DIGITS.
  - CONVERT: sequential double-dabble, exactly WIDTH cycles, then DIGITS.
  - PREFIX0/1: emit '0', then 'b' or 'x'.
  - DIGITS: emit most-significant digit first. The digit index decrements on each handshake.
  - TERM_CR/TERM_LF: entered only if TERM_EN.
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- Latency, hex/bin: start accepted at cycle t gives first char_valid at t+1. With char_ready held high, one character per cycle. done is asserted the cycle after the last handshake.
- Latency, dec: first char_valid at t+1+WIDTH.
- Handshake:
  - char_valid is never dropped and char_out never changes while char_valid & !char_ready.
  - char_valid may rise regardless of char_ready.
  - No combinational path from char_ready to char_valid.
- Leading-zero suppression: when LZ_SUPPRESS=1, the DIGITS state skips zero digits internally (one cycle per skip, valid low) until the first non-zero digit or the last digit. Value 0 prints a single '0'.
- start while busy=1 is ignored; mode and number_in are not re-sampled.
- start in the same cycle as rst: rst wins.
- Latched operands are held stable for the entire transaction, independent of input changes.

Decomposition:
- Package print_pkg:
  - mode encodings MODE_BIN/HEX/DEC
  - ASCII constants (ZERO, LET_A, LET_B, LET_X, CR, LF)
  - state enum
  - function dec_digits(width)
- Sub-module bcd_double_dabble, parameters WIDTH and DIGITS:
  - ports: clk, rst, load, bin_in, busy, bcd_out[4*DIGITS-1:0]
  - iterative shift-add-3, WIDTH cycles
- The digit mux and ASCII mapping stay in the top level.

Test Plan:
1. WIDTH=32, defaults, mode=hex, number_in=32'h0000BEEF, ready=1 -> "0x0000BEEF\r\n", 12 characters on consecutive cycles t+1..t+12, done at t+13.
2. mode=dec, number_in=32'hFFFFFFFF -> valid low for 32 cycles, then "4294967295\r\n"; done pulses once.
3. LZ_SUPPRESS=1, mode=bin, number_in=0 -> "0b0\r\n"; then number_in=5 -> "0b101\r\n".
4. Hex 32'h0000BEEF with char_ready low for 3 cycles while 'E' is presented -> char_out=8'h45 and valid held for all 3 cycles; the sequence is otherwise unchanged.
5. Second start and changed number_in pulsed during an active stream -> ignored, output unchanged; rst asserted mid-DIGITS -> next cycle valid=0, busy=0, no done; a fresh start then works.
6. WIDTH=12, PREFIX_EN=0, TERM_EN=0, mode=hex, 12'hABC -> "ABC"; mode=dec, 12'd4095 -> "4095" (DEC_DIGITS=4).
